subleq_boot_loader: RTL and testbench
=====================================

Name: subleq_boot_loader

Overview:
Upstream stage of the subleq core. Receives a program image as a byte stream and writes it word by word into the core's dual-port memory through one write port. Releases the core (core_run) only after a complete, checksum-valid image has been stored. Sits between the serial receiver and the memory/core pair.

Parameters:
WORD_SIZE, gc::WORD_SIZE (16), memory word and address width
MEM_SIZE, gc::MEM_SIZE (32), number of memory words; maximum image length
BYTES_PER_WORD, (WORD_SIZE+7)/8, bytes per word on the stream

Ports:
clk  in  1  system clock, all logic on its rising edge
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  byte available on rx_data
rx_data  in  8  stream byte
rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at clk edge
mem_add  out  WORD_SIZE  write address (word index)
mem_data_in  out  WORD_SIZE  write data
mem_write  out  1  one-cycle write strobe
core_run  out  1  image loaded and verified; core may execute
load_error  out  1  sticky error flag
words_loaded  out  WORD_SIZE  count of words written

Behaviour:
- Reset (async, any state, including mid-load): state=SYNC; rx_ready=1; mem_write=0; mem_add=0; mem_data_in=0; core_run=0; load_error=0; words_loaded=0; checksum=0; byte counter=0.
- Frame: SYNC byte 0x55, LEN_LO, LEN_HI (16-bit word count N, little-endian), N words at BYTES_PER_WORD bytes each (little-endian, excess high bits of the final byte discarded), CSUM byte.
- States:
  SYNC: accepted bytes other than 0x55 are discarded. 0x55 -> LEN_LO, checksum cleared.
  LEN_LO -> LEN_HI.
  LEN_HI: if N > MEM_SIZE -> ERROR; N==0 -> CSUM; else -> DATA.
  DATA: assemble bytes. On acceptance of the last byte of a word, in the next cycle mem_write=1, mem_add=word index, mem_data_in=assembled word; words_loaded increments in the same cycle. After word N-1 -> CSUM.
  CSUM: accepted byte == running checksum -> DONE, else -> ERROR.
  DONE: core_run=1, rx_ready=0. Held until reset.
  ERROR: load_error=1, core_run=0, rx_ready=0. Held until reset.
- Checksum: XOR of every accepted byte after SYNC up to but excluding CSUM (LEN_LO, LEN_HI, all data bytes).
- rx_ready=1 in SYNC, LEN_LO, LEN_HI, DATA and CSUM, including during a write-strobe cycle. Back-to-back bytes are accepted at one byte per clock with no bubbles.
- Write latency: one clock from acceptance of the word's final byte to mem_write high. mem_write is high for exactly one cycle per word. The final word's write strobe may coincide with CSUM acceptance.
- rx_valid gaps: state and assembly hold; no timeout.
- Words already written before ERROR remain in memory; the core never runs.
- mem_add wraps nowhere: it is bounded by the N <= MEM_SIZE check.

Decomposition:
- gc package: WORD_SIZE, MEM_SIZE (existing); add BOOT_SYNC_BYTE = 8'h55 and the loader state enum typedef (SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR).
- One sub-module: boot_word_assembler. It shifts BYTES_PER_WORD bytes into a WORD_SIZE word and pulses word_done. The FSM, checksum and write port remain in subleq_boot_loader.

Test Plan (WORD_SIZE=16, MEM_SIZE=32):
1. Nominal load: bytes 55 02 00 34 12 05 00 21, rx_valid continuous -> writes mem[0]=0x1234, mem[1]=0x0005, each one cycle after the high byte. words_loaded=2. core_run=1 the cycle after CSUM. load_error=0.
2. Bad checksum: same frame with CSUM=0x20 -> both writes occur; load_error=1; core_run stays 0; rx_ready=0.
3. Oversize: 55 21 00 (N=33) -> ERROR after LEN_HI; no mem_write ever asserted.
4. Empty image and garbage preamble: AA 13 55 00 00 00 -> preamble bytes ignored; no writes; core_run=1; words_loaded=0.
5. Gaps and reset: frame from 1 with rx_valid toggling every other cycle gives results identical to 1. A second run asserts rst after byte 0x34 -> all outputs at reset values immediately; a full frame 1 afterwards loads correctly.
6. Full memory: N=32 (55 20 00, 64 data bytes, correct CSUM) -> 32 writes at mem_add 0..31; core_run=1.

Source files
------------

// File: rtl/subleq_boot_loader_pkg.sv
// Shared constants and loader state encoding for the subleq core.
// Core-wide sizes plus the boot stream sync byte.
package gc;

   localparam int WORD_SIZE = 16;
   localparam int MEM_SIZE  = 32;

   localparam logic [7:0] BOOT_SYNC_BYTE = 8'h55;

   typedef enum logic [2:0] {
      SYNC   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } boot_state_e;

endpackage

// File: rtl/subleq_boot_loader_word_asm.sv
// Little-endian byte-to-word assembler for the boot loader.
// word_o/word_done_o reflect the byte being accepted this cycle.
module boot_word_assembler
   import gc::*;
#(
   parameter int WORD_SIZE      = gc::WORD_SIZE,
   parameter int BYTES_PER_WORD = (WORD_SIZE + 7) / 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 byte_valid_i,
   input  logic [7:0]           byte_i,
   output logic [WORD_SIZE-1:0] word_o,
   output logic                 word_done_o
);

   localparam int AW = BYTES_PER_WORD * 8;
   localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last;

   assign last = (cnt_q == CW'(BYTES_PER_WORD - 1));

   // New bytes enter at the top so the first byte ends up least significant.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (byte_valid_i) begin
         acc_d = (acc_q >> 8) | (AW'(byte_i) << (AW - 8));
         cnt_d = last ? '0 : cnt_q + CW'(1);
      end
   end

   assign word_o      = acc_d[WORD_SIZE-1:0];
   assign word_done_o = byte_valid_i && last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/subleq_boot_loader.sv
// Boot loader: parses a framed byte stream, writes words into core memory,
// and releases the core only after a checksum-valid image is stored.
module subleq_boot_loader
   import gc::*;
#(
   parameter int WORD_SIZE      = gc::WORD_SIZE,
   parameter int MEM_SIZE       = gc::MEM_SIZE,
   parameter int BYTES_PER_WORD = (WORD_SIZE + 7) / 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic [WORD_SIZE-1:0] mem_add,
   output logic [WORD_SIZE-1:0] mem_data_in,
   output logic                 mem_write,
   output logic                 core_run,
   output logic                 load_error,
   output logic [WORD_SIZE-1:0] words_loaded
);

   boot_state_e state_q, state_d;

   logic [7:0]           csum_q, csum_d;
   logic [7:0]           len_lo_q, len_lo_d;
   logic [15:0]          len_q, len_d;
   logic [15:0]          len_n;
   logic [WORD_SIZE-1:0] words_q, words_d;
   logic [WORD_SIZE-1:0] add_q, add_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 wr_q, wr_d;
   logic                 accept;
   logic                 last_word;
   logic [WORD_SIZE-1:0] asm_word;
   logic                 asm_done;

   assign accept    = rx_valid && rx_ready;
   assign len_n     = {rx_data, len_lo_q};
   assign last_word = (words_q == WORD_SIZE'(len_q - 16'd1));

   boot_word_assembler #(
      .WORD_SIZE      (WORD_SIZE),
      .BYTES_PER_WORD (BYTES_PER_WORD)
   ) u_asm (
      .clk          (clk),
      .rst          (rst),
      .byte_valid_i (accept && (state_q == DATA)),
      .byte_i       (rx_data),
      .word_o       (asm_word),
      .word_done_o  (asm_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SYNC;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SYNC:   if (accept && rx_data == BOOT_SYNC_BYTE) state_d = LEN_LO;
         LEN_LO: if (accept) state_d = LEN_HI;
         LEN_HI: if (accept) begin
            if (len_n > 16'(MEM_SIZE)) state_d = ERROR;
            else if (len_n == 16'd0)   state_d = CSUM;
            else                       state_d = DATA;
         end
         DATA:   if (asm_done && last_word) state_d = CSUM;
         CSUM:   if (accept) state_d = (rx_data == csum_q) ? DONE : ERROR;
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      rx_ready   = 1'b0;
      core_run   = 1'b0;
      load_error = 1'b0;
      unique case (state_q)
         SYNC, LEN_LO, LEN_HI, DATA, CSUM: rx_ready = 1'b1;
         DONE:    core_run   = 1'b1;
         ERROR:   load_error = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      csum_d   = csum_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      words_d  = words_q;
      add_d    = add_q;
      wdata_d  = wdata_q;
      wr_d     = 1'b0;
      if (accept) begin
         unique case (state_q)
            SYNC:   csum_d = '0;
            LEN_LO: begin
               csum_d   = csum_q ^ rx_data;
               len_lo_d = rx_data;
            end
            LEN_HI: begin
               csum_d = csum_q ^ rx_data;
               len_d  = len_n;
            end
            DATA: begin
               csum_d = csum_q ^ rx_data;
               if (asm_done) begin
                  wr_d    = 1'b1;
                  add_d   = words_q;
                  wdata_d = asm_word;
                  words_d = words_q + WORD_SIZE'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_q   <= '0;
         len_lo_q <= '0;
         len_q    <= '0;
         words_q  <= '0;
         add_q    <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
      end else begin
         csum_q   <= csum_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         words_q  <= words_d;
         add_q    <= add_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
      end
   end

   assign mem_write    = wr_q;
   assign mem_add      = add_q;
   assign mem_data_in  = wdata_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_subleq_boot_loader.sv
// Directed bench for subleq_boot_loader (WORD_SIZE=16, MEM_SIZE=32).
module tb_subleq_boot_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic [15:0] mem_add;
   logic [15:0] mem_data_in;
   logic        mem_write;
   logic        core_run;
   logic        load_error;
   logic [15:0] words_loaded;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [15:0] mem_model [0:63];
   logic [15:0] add_seen  [0:63];
   int          wr_count = 0;

   logic [7:0] f1 [0:7] = '{8'h55, 8'h02, 8'h00, 8'h34,
                            8'h12, 8'h05, 8'h00, 8'h21};

   subleq_boot_loader dut (
      .clk          (clk),
      .rst          (rst),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .mem_add      (mem_add),
      .mem_data_in  (mem_data_in),
      .mem_write    (mem_write),
      .core_run     (core_run),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Memory model: capture every strobe at the falling edge.
   always @(negedge clk) begin
      if (!rst && mem_write) begin
         if (mem_add < 16'd64) mem_model[mem_add[5:0]] = mem_data_in;
         if (wr_count < 64) add_seen[wr_count] = mem_add;
         wr_count = wr_count + 1;
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 64; i++) begin
         mem_model[i] = 16'hDEAD;
         add_seen[i]  = 16'hFFFF;
      end
      wr_count = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      rst = 1'b1;
      #1 clear_model();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_gap(input logic [7:0] b);
      send(b);
      @(negedge clk);
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({rx_ready, mem_write, mem_add, mem_data_in, core_run, load_error, words_loaded}
          !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0})
         $display("FAIL reset_state: got rdy=%b wr=%b add=%h dat=%h run=%b err=%b wl=%h",
                  rx_ready, mem_write, mem_add, mem_data_in, core_run, load_error, words_loaded);
      else pass_cnt++;
   endtask

   task automatic test_nominal();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(f1[i]);
         if (i == 3) begin
            total_cnt++;
            if (mem_write !== 1'b0)
               $display("FAIL nom_no_early_write: got %b want 0", mem_write);
            else pass_cnt++;
         end
         if (i == 4) begin
            total_cnt++;
            if ({mem_write, mem_add, mem_data_in, words_loaded} !== {1'b1, 16'd0, 16'h1234, 16'd1})
               $display("FAIL nom_write0: got wr=%b add=%h dat=%h wl=%h want 1 0000 1234 0001",
                        mem_write, mem_add, mem_data_in, words_loaded);
            else pass_cnt++;
         end
         if (i == 5) begin
            total_cnt++;
            if ({mem_write, rx_ready} !== 2'b01)
               $display("FAIL nom_strobe_width: got wr=%b rdy=%b want 0 1", mem_write, rx_ready);
            else pass_cnt++;
         end
         if (i == 6) begin
            total_cnt++;
            if ({mem_write, mem_add, mem_data_in} !== {1'b1, 16'd1, 16'h0005})
               $display("FAIL nom_write1: got wr=%b add=%h dat=%h want 1 0001 0005",
                        mem_write, mem_add, mem_data_in);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if ({core_run, load_error, rx_ready} !== 3'b100)
         $display("FAIL nom_done: got run/err/rdy=%b want 100", {core_run, load_error, rx_ready});
      else pass_cnt++;
      idle(3);
      total_cnt++;
      if ({words_loaded, mem_model[0], mem_model[1]} !== {16'd2, 16'h1234, 16'h0005} || wr_count != 2)
         $display("FAIL nom_image: got wl=%h m0=%h m1=%h writes=%0d want 0002 1234 0005 2",
                  words_loaded, mem_model[0], mem_model[1], wr_count);
      else pass_cnt++;
   endtask

   task automatic test_bad_csum();
      do_reset();
      for (int i = 0; i < 7; i++) send(f1[i]);
      send(8'h20);
      idle(3);
      total_cnt++;
      if ({core_run, load_error, rx_ready} !== 3'b010)
         $display("FAIL bad_csum_flags: got run/err/rdy=%b want 010", {core_run, load_error, rx_ready});
      else pass_cnt++;
      total_cnt++;
      if (wr_count != 2 || {mem_model[0], mem_model[1]} !== {16'h1234, 16'h0005})
         $display("FAIL bad_csum_writes: got writes=%0d m0=%h m1=%h want 2 1234 0005",
                  wr_count, mem_model[0], mem_model[1]);
      else pass_cnt++;
   endtask

   task automatic test_oversize();
      do_reset();
      send(8'h55);
      send(8'h21);
      send(8'h00);
      send(8'h11);
      send(8'h22);
      idle(3);
      total_cnt++;
      if ({core_run, load_error, rx_ready} !== 3'b010)
         $display("FAIL oversize_flags: got run/err/rdy=%b want 010", {core_run, load_error, rx_ready});
      else pass_cnt++;
      total_cnt++;
      if (wr_count != 0 || words_loaded !== 16'd0)
         $display("FAIL oversize_no_write: got writes=%0d wl=%h want 0 0000", wr_count, words_loaded);
      else pass_cnt++;
   endtask

   task automatic test_empty();
      do_reset();
      send(8'hAA);
      send(8'h13);
      total_cnt++;
      if ({core_run, load_error, rx_ready} !== 3'b001)
         $display("FAIL preamble_ignored: got run/err/rdy=%b want 001", {core_run, load_error, rx_ready});
      else pass_cnt++;
      send(8'h55);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      idle(3);
      total_cnt++;
      if ({core_run, load_error, rx_ready} !== 3'b100 || words_loaded !== 16'd0 || wr_count != 0)
         $display("FAIL empty_image: got run/err/rdy=%b wl=%h writes=%0d want 100 0000 0",
                  {core_run, load_error, rx_ready}, words_loaded, wr_count);
      else pass_cnt++;
   endtask

   task automatic test_gaps();
      do_reset();
      for (int i = 0; i < 8; i++) send_gap(f1[i]);
      idle(3);
      total_cnt++;
      if ({core_run, load_error, words_loaded} !== {2'b10, 16'd2} || wr_count != 2
          || {mem_model[0], mem_model[1]} !== {16'h1234, 16'h0005})
         $display("FAIL gaps_image: got run=%b err=%b wl=%h writes=%0d m0=%h m1=%h",
                  core_run, load_error, words_loaded, wr_count, mem_model[0], mem_model[1]);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) send(f1[i]);
      #1 rst = 1'b1;
      #1;
      total_cnt++;
      if ({rx_ready, mem_write, mem_add, mem_data_in, core_run, load_error, words_loaded}
          !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0})
         $display("FAIL mid_reset_state: got rdy=%b wr=%b add=%h dat=%h run=%b err=%b wl=%h",
                  rx_ready, mem_write, mem_add, mem_data_in, core_run, load_error, words_loaded);
      else pass_cnt++;
      @(negedge clk);
      rx_valid = 1'b0;
      clear_model();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) send(f1[i]);
      idle(3);
      total_cnt++;
      if ({core_run, load_error, words_loaded} !== {2'b10, 16'd2} || wr_count != 2
          || {mem_model[0], mem_model[1]} !== {16'h1234, 16'h0005})
         $display("FAIL after_reset_load: got run=%b err=%b wl=%h writes=%0d m0=%h m1=%h",
                  core_run, load_error, words_loaded, wr_count, mem_model[0], mem_model[1]);
      else pass_cnt++;
   endtask

   task automatic test_full();
      logic [15:0] w;
      logic [7:0]  cs;
      int          bad_data;
      int          bad_add;
      do_reset();
      cs = 8'h20 ^ 8'h00;
      send(8'h55);
      send(8'h20);
      send(8'h00);
      for (int i = 0; i < 32; i++) begin
         w = 16'hC300 + 16'(i) * 16'h0101;
         send(w[7:0]);
         send(w[15:8]);
         cs = cs ^ w[7:0] ^ w[15:8];
      end
      send(cs);
      idle(3);
      bad_data = 0;
      bad_add  = 0;
      for (int i = 0; i < 32; i++) begin
         w = 16'hC300 + 16'(i) * 16'h0101;
         if (mem_model[i] !== w) bad_data++;
         if (add_seen[i] !== 16'(i)) bad_add++;
      end
      total_cnt++;
      if (bad_data != 0)
         $display("FAIL full_data: got %0d bad words want 0", bad_data);
      else pass_cnt++;
      total_cnt++;
      if (bad_add != 0 || wr_count != 32)
         $display("FAIL full_addr: got %0d bad addrs, writes=%0d want 0 32", bad_add, wr_count);
      else pass_cnt++;
      total_cnt++;
      if ({core_run, load_error, words_loaded} !== {2'b10, 16'd32})
         $display("FAIL full_done: got run=%b err=%b wl=%h want 1 0 0020",
                  core_run, load_error, words_loaded);
      else pass_cnt++;
   endtask

   initial begin
      clear_model();
      test_reset();
      test_nominal();
      test_bad_csum();
      test_oversize();
      test_empty();
      test_gaps();
      test_reset_mid();
      test_full();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
